// File: rtl/uvmt_sb_st_clknrst_chk.sv
`default_nettype none
// ============================================================================
// Module      : uvmt_sb_st_clknrst_chk
// Description : Clock/reset checker. Tracks the reset sequence through a
//               three-state FSM (IN_RST -> SETTLE -> READY), measures the
//               length of each reset pulse, and raises sticky errors for a
//               too-short reset pulse or a reset_n that is not the
//               complement of reset. Optionally counts cycles spent in READY.
// Ports       : clk           - sole clock, rising edge
//               reset         - synchronous active-high reset (also monitored)
//               reset_n       - monitored companion reset, expected ~reset
//               clr_err       - single-cycle clear of sticky errors
//               state         - 0 IN_RST, 1 SETTLE, 2 READY
//               rst_done      - high only in READY
//               rst_len       - length of current / most recent reset pulse
//               err_short_rst - sticky: last pulse shorter than MIN_RST_CYC
//               err_polarity  - sticky: reset_n not complementary to reset
//               cyc_cnt       - cycles spent in READY (saturating)
// Config      : define UVMT_SB_ST_CLKNRST_CHK_CYC_CNT_EN to build the READY
//               cycle counter; otherwise cyc_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module uvmt_sb_st_clknrst_chk #(
    parameter int unsigned MIN_RST_CYC = 4,
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reset_n,
    input  logic             clr_err,
    output logic [1:0]       state,
    output logic             rst_done,
    output logic [15:0]      rst_len,
    output logic             err_short_rst,
    output logic             err_polarity,
    output logic [CNT_W-1:0] cyc_cnt
);

    typedef enum logic [1:0] {
        ST_IN_RST = 2'd0,
        ST_SETTLE = 2'd1,
        ST_READY  = 2'd2
    } st_e;

    localparam logic [15:0] c_min_len     = 16'(MIN_RST_CYC);
    // Guarded so a zero settle time does not wrap; unused in that case.
    localparam logic [15:0] c_settle_last = 16'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);

    st_e         state_q,         state_d;
    logic        rst_done_q,      rst_done_d;
    logic [15:0] rst_len_q,       rst_len_d;
    logic        err_short_rst_q, err_short_rst_d;
    logic        err_polarity_q,  err_polarity_d;
    logic        pol_bad_q,       pol_bad_d;
    logic [15:0] settle_cnt_q,    settle_cnt_d;
    logic        reset_q;
    logic [CNT_W-1:0] cyc_cnt_q,  cyc_cnt_d;

    logic rst_first;
    logic set_short;
    logic set_pol;

    always_comb begin
        // A pulse starts when the previous sample of reset was low.
        rst_first = reset & ~reset_q;

        rst_len_d = rst_len_q;
        pol_bad_d = pol_bad_q;
        if (reset) begin
            if (rst_first) begin
                rst_len_d = 16'd1;
            end else if (rst_len_q != 16'hFFFF) begin
                rst_len_d = rst_len_q + 16'd1;
            end
            // pol_bad restarts with each pulse, then accumulates any cycle
            // where reset_n failed to go low alongside reset.
            pol_bad_d = (rst_first ? 1'b0 : pol_bad_q) | reset_n;
        end

        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        set_short    = 1'b0;
        set_pol      = 1'b0;
        if (reset) begin
            state_d      = ST_IN_RST;
            settle_cnt_d = 16'd0;
        end else begin
            case (state_q)
                ST_IN_RST: begin
                    // Release edge: judge the pulse that just ended.
                    set_short    = (rst_len_q < c_min_len);
                    set_pol      = pol_bad_q;
                    settle_cnt_d = 16'd0;
                    state_d      = (SETTLE_CYC == 0) ? ST_READY : ST_SETTLE;
                end
                ST_SETTLE: begin
                    settle_cnt_d = settle_cnt_q + 16'd1;
                    if (settle_cnt_q == c_settle_last) begin
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    state_d = ST_READY;
                end
                default: begin
                    state_d = ST_IN_RST;
                end
            endcase
            if (!reset_n) begin
                set_pol = 1'b1;
            end
        end

        err_short_rst_d = err_short_rst_q;
        err_polarity_d  = err_polarity_q;
        if (!reset && clr_err) begin
            err_short_rst_d = 1'b0;
            err_polarity_d  = 1'b0;
        end
        // A set on the same edge wins over the clear.
        err_short_rst_d = err_short_rst_d | set_short;
        err_polarity_d  = err_polarity_d  | set_pol;

        rst_done_d = (state_d == ST_READY);

`ifdef UVMT_SB_ST_CLKNRST_CHK_CYC_CNT_EN
        cyc_cnt_d = cyc_cnt_q;
        if (state_q == ST_READY) begin
            if (cyc_cnt_q != {CNT_W{1'b1}}) begin
                cyc_cnt_d = cyc_cnt_q + 1'b1;
            end
        end else if (state_d == ST_READY) begin
            cyc_cnt_d = '0;
        end
`else
        cyc_cnt_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        reset_q   <= reset;
        rst_len_q <= rst_len_d;
        pol_bad_q <= pol_bad_d;
        if (reset) begin
            state_q         <= ST_IN_RST;
            rst_done_q      <= 1'b0;
            err_short_rst_q <= 1'b0;
            err_polarity_q  <= 1'b0;
            settle_cnt_q    <= 16'd0;
            cyc_cnt_q       <= '0;
        end else begin
            state_q         <= state_d;
            rst_done_q      <= rst_done_d;
            err_short_rst_q <= err_short_rst_d;
            err_polarity_q  <= err_polarity_d;
            settle_cnt_q    <= settle_cnt_d;
            cyc_cnt_q       <= cyc_cnt_d;
        end
    end

    assign state         = state_q;
    assign rst_done      = rst_done_q;
    assign rst_len       = rst_len_q;
    assign err_short_rst = err_short_rst_q;
    assign err_polarity  = err_polarity_q;
    assign cyc_cnt       = cyc_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uvmt_sb_st_clknrst_chk.sv
`default_nettype none
// ============================================================================
// Module      : tb_uvmt_sb_st_clknrst_chk
// Description : Self-checking bench for uvmt_sb_st_clknrst_chk. Two
//               instances share stimulus: one with default parameters, one
//               with zero settle time and an 8-bit READY counter. A
//               reference model tracks edges since reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uvmt_sb_st_clknrst_chk;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reset_n = 1'b1;
    logic clr_err = 1'b0;

    logic [1:0]  st_a,  st_b;
    logic        dn_a,  dn_b;
    logic [15:0] len_a, len_b;
    logic        es_a,  es_b;
    logic        ep_a,  ep_b;
    logic [31:0] cyc_a;
    logic [7:0]  cyc_b;

    always #5 clk = ~clk;

    uvmt_sb_st_clknrst_chk u_dut_a (
        .clk(clk), .reset(reset), .reset_n(reset_n), .clr_err(clr_err),
        .state(st_a), .rst_done(dn_a), .rst_len(len_a),
        .err_short_rst(es_a), .err_polarity(ep_a), .cyc_cnt(cyc_a)
    );

    uvmt_sb_st_clknrst_chk #(
        .MIN_RST_CYC(2), .SETTLE_CYC(0), .CNT_W(8)
    ) u_dut_b (
        .clk(clk), .reset(reset), .reset_n(reset_n), .clr_err(clr_err),
        .state(st_b), .rst_done(dn_b), .rst_len(len_b),
        .err_short_rst(es_b), .err_polarity(ep_b), .cyc_cnt(cyc_b)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: per instance, counts edges since the last reset edge.
    int              c_settle [2] = '{8, 0};
    int              c_min    [2] = '{4, 2};
    longint unsigned c_cmax   [2] = '{64'hFFFF_FFFF, 64'd255};

    int  m_len   [2] = '{0, 0};
    bit  m_prev  [2] = '{1'b0, 1'b0};
    bit  m_pb    [2] = '{1'b0, 1'b0};
    int  m_since [2] = '{-1, -1};  // -1: no reset seen yet
    bit  m_es    [2] = '{1'b0, 1'b0};
    bit  m_ep    [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_len[i]   = m_prev[i] ? ((m_len[i] < 65535) ? m_len[i] + 1 : 65535) : 1;
                m_pb[i]    = (m_prev[i] ? m_pb[i] : 1'b0) | reset_n;
                m_since[i] = 0;
                m_es[i]    = 1'b0;
                m_ep[i]    = 1'b0;
            end else begin
                bit s_short;
                bit s_pol;
                s_short = (m_since[i] == 0) && (m_len[i] < c_min[i]);
                s_pol   = ((m_since[i] == 0) && m_pb[i]) || !reset_n;
                if (clr_err) begin
                    m_es[i] = 1'b0;
                    m_ep[i] = 1'b0;
                end
                m_es[i] = m_es[i] | s_short;
                m_ep[i] = m_ep[i] | s_pol;
                if (m_since[i] >= 0) m_since[i] = m_since[i] + 1;
            end
            m_prev[i] = reset;
        end
    end

    task automatic check_one(input int i, input longint unsigned o_st, input longint unsigned o_dn,
                             input longint unsigned o_len, input longint unsigned o_es,
                             input longint unsigned o_ep, input longint unsigned o_cyc);
        longint unsigned e_st;
        longint unsigned e_cyc;
        if (m_since[i] < 0) return;
        if (m_since[i] == 0)                  e_st = 0;
        else if (m_since[i] >= c_settle[i] + 1) e_st = 2;
        else                                  e_st = 1;
        e_cyc = 0;
`ifdef UVMT_SB_ST_CLKNRST_CHK_CYC_CNT_EN
        if (e_st == 2) begin
            e_cyc = longint'(m_since[i] - c_settle[i] - 1);
            if (e_cyc > c_cmax[i]) e_cyc = c_cmax[i];
        end
`endif
        chk($sformatf("state[%0d]", i),         o_st,  e_st);
        chk($sformatf("rst_done[%0d]", i),      o_dn,  (e_st == 2) ? 1 : 0);
        chk($sformatf("rst_len[%0d]", i),       o_len, longint'(m_len[i]));
        chk($sformatf("err_short_rst[%0d]", i), o_es,  longint'(m_es[i]));
        chk($sformatf("err_polarity[%0d]", i),  o_ep,  longint'(m_ep[i]));
        chk($sformatf("cyc_cnt[%0d]", i),       o_cyc, e_cyc);
    endtask

    task automatic cyc(input bit r, input bit rn, input bit c);
        reset   = r;
        reset_n = rn;
        clr_err = c;
        @(posedge clk);
        #1;
        check_one(0, st_a, dn_a, len_a, es_a, ep_a, cyc_a);
        check_one(1, st_b, dn_b, len_b, es_b, ep_b, cyc_b);
    endtask

    task automatic pulse(input int n_rst, input bit rn_in_rst, input int n_idle);
        for (int k = 0; k < n_rst; k++)  cyc(1'b1, rn_in_rst, 1'b0);
        for (int k = 0; k < n_idle; k++) cyc(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        // Known low reset sample before the first pulse.
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);

        // Clean 6-cycle reset, settle into READY.
        pulse(6, 1'b0, 12);
        chk("len_after_clean", len_a, 6);
        chk("ready_after_clean", dn_a, 1);

        // Short 2-cycle reset, then clear the sticky error.
        pulse(2, 1'b0, 3);
        chk("short_flag", es_a, 1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("short_cleared", es_a, 0);
        pulse(0, 1'b0, 8);

        // reset_n stuck high during a 5-cycle reset.
        pulse(5, 1'b1, 12);
        chk("pol_from_release", ep_a, 1);
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);   // glitch on reset_n while READY
        chk("pol_glitch", ep_a, 1);
        cyc(1'b0, 1'b1, 1'b1);

        // Reassert reset mid-settle (counter at 3 for the default instance).
        pulse(5, 1'b0, 4);
        cyc(1'b1, 1'b0, 1'b0);
        chk("reassert_state", st_a, 0);
        chk("reassert_len", len_a, 1);

        // Long READY stretch: saturates the 8-bit counter.
        pulse(4, 1'b0, 300);

        // Clear on the same edge as a short-reset release: set wins.
        pulse(1, 1'b0, 0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("set_beats_clear", es_a, 1);
        // clr_err ignored during reset.
        cyc(1'b1, 1'b0, 1'b1);

        // Randomized pulses, polarity glitches and clears.
        for (int p = 0; p < 40; p++) begin
            int n_r;
            int n_i;
            n_r = int'($urandom_range(1, 7));
            n_i = int'($urandom_range(0, 14));
            for (int k = 0; k < n_r; k++)
                cyc(1'b1, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
            for (int k = 0; k < n_i; k++)
                cyc(1'b0, ($urandom_range(0, 11) != 0), ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
